// File: rtl/adc_pattern_gen.sv
// -----------------------------------------------------------------------------
// adc_pattern_gen
//
// Multi-channel ADC stimulus source. Each channel produces a sample word
// (constant, ramp, pseudo-random or alternating bits), the complement of that
// word for differential-pair emulation, and a shared data-valid strobe whose
// density is set by a 16-bit LFSR compared against valid_ratio_i.
//
// Ports:
//   clk_sys_i      system clock, rising edge
//   sys_rst_n_i    asynchronous active-low reset
//   en_i           generator enable; low freezes all state, valid_o forced low
//   clr_i          synchronous clear of pattern state and sample counter
//   mode_i         0 constant, 1 ramp, 2 pseudo-random, 3 alternating
//   const_i        value driven on every channel in mode 0
//   valid_ratio_i  valid density (8'hFF = every enabled cycle, 0 = never)
//   data_o         channel k at bits [k*W +: W]
//   data_n_o       bitwise complement of data_o, same cycle
//   valid_o        sample strobe
//   sample_cnt_o   valid_o pulses since reset/clear, wraps
// -----------------------------------------------------------------------------
module adc_pattern_gen #(
   parameter int unsigned g_num_channels = 4,
   parameter int unsigned g_data_width   = 16,
   parameter logic [31:0] g_lfsr_seed    = 32'h1234_5678
) (
   input  logic                                     clk_sys_i,
   input  logic                                     sys_rst_n_i,
   input  logic                                     en_i,
   input  logic                                     clr_i,
   input  logic [1:0]                               mode_i,
   input  logic [g_data_width-1:0]                  const_i,
   input  logic [7:0]                               valid_ratio_i,
   output logic [g_num_channels*g_data_width-1:0]   data_o,
   output logic [g_num_channels*g_data_width-1:0]   data_n_o,
   output logic                                     valid_o,
   output logic [31:0]                              sample_cnt_o
);

   localparam int unsigned NC = g_num_channels;
   localparam int unsigned W  = g_data_width;

   typedef logic [W-1:0] word_t;

   // Per-channel LFSR seed; an all-zero seed would lock the LFSR, so use 1.
   function automatic logic [31:0] seed_f(input int unsigned k);
      logic [31:0] s;
      s = g_lfsr_seed + 32'(k);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

   function automatic word_t ramp_init_f(input int unsigned k);
      logic [31:0] kk;
      kk = 32'(k);
      return kk[W-1:0];
   endfunction

   // 32-bit Galois LFSR, right shift, mask applied when the shifted-out bit is 1.
   function automatic logic [31:0] galois_step_f(input logic [31:0] l);
      return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
   endfunction

   // 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1 (right-shift form).
   function automatic logic [15:0] vlfsr_step_f(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   // odd=0 gives ...0101 (LSB set), odd=1 gives ...1010.
   function automatic word_t alt_word_f(input logic odd);
      word_t w;
      for (int i = 0; i < int'(W); i++) begin
         w[i] = ((i % 2) == 0) ^ odd;
      end
      return w;
   endfunction

   logic [NC*W-1:0] data_p0;
   logic [NC*W-1:0] data_n_p0;
   logic            vld_p0;
   logic [31:0]     cnt_p0;

   logic [1:0]      mode_q;
   logic [15:0]     vlfsr_q;
   logic            phase_q;
   word_t           ramp_q [NC];
   logic [31:0]     lfsr_q [NC];

   logic [NC*W-1:0] pat;
   logic            dec;
   logic            reload;

   assign dec    = (valid_ratio_i == 8'hFF) || (vlfsr_q[7:0] < valid_ratio_i);
   assign reload = clr_i || (mode_i != mode_q);

   always_comb begin
      pat = '0;
      for (int k = 0; k < int'(NC); k++) begin
         case (mode_q)
            2'd0:    pat[k*W +: W] = const_i;
            2'd1:    pat[k*W +: W] = ramp_q[k];
            2'd2:    pat[k*W +: W] = lfsr_q[k][W-1:0];
            default: pat[k*W +: W] = alt_word_f(phase_q ^ k[0]);
         endcase
      end
   end

   // ---- stage p0: pattern state, valid decision, output register ----
   always_ff @(posedge clk_sys_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         data_p0   <= '0;
         data_n_p0 <= '1;
         vld_p0    <= 1'b0;
         cnt_p0    <= 32'd0;
         mode_q    <= 2'd0;
         vlfsr_q   <= 16'hACE1;
         phase_q   <= 1'b0;
         for (int k = 0; k < int'(NC); k++) begin
            ramp_q[k] <= ramp_init_f(k);
            lfsr_q[k] <= seed_f(k);
         end
      end else begin
         mode_q <= mode_i;
         vld_p0 <= 1'b0;
         if (en_i) begin
            vlfsr_q <= vlfsr_step_f(vlfsr_q);
         end
         if (reload) begin
            // Clear and mode change share one reload; data_o holds.
            phase_q <= 1'b0;
            for (int k = 0; k < int'(NC); k++) begin
               ramp_q[k] <= ramp_init_f(k);
               lfsr_q[k] <= seed_f(k);
            end
            if (clr_i) begin
               cnt_p0 <= 32'd0;
            end
         end else if (en_i && dec) begin
            data_p0   <= pat;
            data_n_p0 <= ~pat;
            vld_p0    <= 1'b1;
            cnt_p0    <= cnt_p0 + 32'd1;
            // Only the state of the active pattern advances.
            case (mode_q)
               2'd1: begin
                  for (int k = 0; k < int'(NC); k++) begin
                     ramp_q[k] <= ramp_q[k] + 1'b1;
                  end
               end
               2'd2: begin
                  for (int k = 0; k < int'(NC); k++) begin
                     lfsr_q[k] <= galois_step_f(lfsr_q[k]);
                  end
               end
               2'd3:    phase_q <= ~phase_q;
               default: ;
            endcase
         end
      end
   end

   assign data_o       = data_p0;
   assign data_n_o     = data_n_p0;
   assign valid_o      = vld_p0;
   assign sample_cnt_o = cnt_p0;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Directed bench for adc_pattern_gen with N=4 channels of W=8 bits.
// Expected samples are queued before each stimulus phase; a monitor pops one
// entry per valid_o pulse and compares data, complement and counter.
module tb_adc_pattern_gen;

   localparam int NC = 4;
   localparam int W  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             clr;
   logic [1:0]       mode;
   logic [W-1:0]     cval;
   logic [7:0]       ratio;
   logic [NC*W-1:0]  data_o;
   logic [NC*W-1:0]  data_n_o;
   logic             valid_o;
   logic [31:0]      sample_cnt_o;

   typedef struct {
      logic [31:0] data;
      logic [31:0] mask;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   vcount   = 0;
   bit   sb_on    = 1'b1;

   always #5 clk = ~clk;

   adc_pattern_gen #(
      .g_num_channels(NC),
      .g_data_width  (W),
      .g_lfsr_seed   (32'h1234_5678)
   ) dut (
      .clk_sys_i    (clk),
      .sys_rst_n_i  (rst_n),
      .en_i         (en),
      .clr_i        (clr),
      .mode_i       (mode),
      .const_i      (cval),
      .valid_ratio_i(ratio),
      .data_o       (data_o),
      .data_n_o     (data_n_o),
      .valid_o      (valid_o),
      .sample_cnt_o (sample_cnt_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [31:0] m, input logic [31:0] c);
      exp_t e;
      e.data = d;
      e.mask = m;
      e.cnt  = c;
      sb_q.push_back(e);
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && valid_o) begin
            vcount++;
            if (sb_on) begin
               checks++;
               if (sb_q.size() == 0) begin
                  failures++;
                  $display("FAIL sb_unexpected_valid actual data=%h cnt=%0d required no pulse",
                           data_o, sample_cnt_o);
               end else begin
                  e = sb_q.pop_front();
                  if ((((data_o ^ e.data) & e.mask) != 32'd0) ||
                      (((data_n_o ^ ~e.data) & e.mask) != 32'd0) ||
                      (sample_cnt_o !== e.cnt)) begin
                     failures++;
                     $display("FAIL sb_sample actual data=%h data_n=%h cnt=%0d required data=%h data_n=%h cnt=%0d mask=%h",
                              data_o, data_n_o, sample_cnt_o, e.data, ~e.data, e.cnt, e.mask);
                  end
               end
            end
         end
      end
   endtask

   task automatic drain_check(input string nm);
      @(negedge clk);
      #1;
      chk(nm, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int v0;
      int d;
      fork
         monitor_loop();
      join_none

      rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'd0; cval = '0; ratio = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data",   data_o,       32'h0000_0000);
      chk("rst_data_n", data_n_o,     32'hFFFF_FFFF);
      chk("rst_valid",  32'(valid_o), 32'd0);
      chk("rst_cnt",    sample_cnt_o, 32'd0);
      rst_n = 1'b1;

      // Ramp: channel k starts at k, wraps 255 -> 0 on every channel.
      for (int i = 0; i < 258; i++) begin
         push({8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, 32'hFFFF_FFFF, 32'(i + 1));
      end
      @(posedge clk); #1;
      mode = 2'd1; en = 1'b1;
      repeat (259) @(posedge clk);
      #1 en = 1'b0;
      drain_check("ramp_drain");
      chk("ramp_cnt", sample_cnt_o, 32'd258);

      // Alternating, then constant 3C after one reload cycle.
      push(32'hAA55_AA55, 32'hFFFF_FFFF, 32'd259);
      push(32'h55AA_55AA, 32'hFFFF_FFFF, 32'd260);
      push(32'hAA55_AA55, 32'hFFFF_FFFF, 32'd261);
      push(32'h55AA_55AA, 32'hFFFF_FFFF, 32'd262);
      push(32'h3C3C_3C3C, 32'hFFFF_FFFF, 32'd263);
      push(32'h3C3C_3C3C, 32'hFFFF_FFFF, 32'd264);
      push(32'h3C3C_3C3C, 32'hFFFF_FFFF, 32'd265);
      @(posedge clk); #1;
      mode = 2'd3; en = 1'b1;
      repeat (5) @(posedge clk);
      #1 mode = 2'd0; cval = 8'h3C;
      @(posedge clk); #1;
      chk("modechg_valid", 32'(valid_o), 32'd0);
      chk("modechg_hold",  data_o,       32'h55AA_55AA);
      repeat (3) @(posedge clk);
      #1 en = 1'b0;
      drain_check("alt_const_drain");

      // Pseudo-random: ch0 seed 0x12345678, ch1 seed 0x12345679 (low bytes).
      for (int r = 0; r < 2; r++) begin
         push(32'h0000_7978, 32'h0000_FFFF, (r == 0) ? 32'd266 : 32'd1);
         push(32'h0000_3F3C, 32'h0000_FFFF, (r == 0) ? 32'd267 : 32'd2);
         push(32'h0000_9C9E, 32'h0000_FFFF, (r == 0) ? 32'd268 : 32'd3);
         push(32'h0000_CECF, 32'h0000_FFFF, (r == 0) ? 32'd269 : 32'd4);
         push(32'h0000_6764, 32'h0000_FFFF, (r == 0) ? 32'd270 : 32'd5);
      end
      @(posedge clk); #1;
      mode = 2'd2; en = 1'b1;
      repeat (6) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_cnt",   sample_cnt_o,          32'd0);
      chk("clr_valid", 32'(valid_o),          32'd0);
      chk("clr_hold",  data_o & 32'h0000_FFFF, 32'h0000_6764);
      repeat (5) @(posedge clk);
      #1 en = 1'b0;
      drain_check("prng_drain");

      // Enable low: no strobe, data frozen.
      v0 = vcount;
      repeat (20) @(posedge clk);
      #1;
      chk("en0_pulses", 32'(vcount - v0),        32'd0);
      chk("en0_data",   data_o & 32'h0000_FFFF,  32'h0000_6764);
      chk("en0_cnt",    sample_cnt_o,            32'd5);

      // Density at ratio 0x80 over one full valid-LFSR period.
      sb_on = 1'b0;
      ratio = 8'h80;
      v0 = vcount;
      @(posedge clk); #1 en = 1'b1;
      repeat (65535) @(posedge clk);
      #1 en = 1'b0;
      @(negedge clk); #1;
      d = vcount - v0;
      chk("density_in_range", 32'((d >= 31457) && (d <= 34079)), 32'd1);
      chk("density_cnt",      sample_cnt_o, 32'(5 + d));

      // Ratio 0: never valid.
      ratio = 8'h00;
      v0 = vcount;
      @(posedge clk); #1 en = 1'b1;
      repeat (1000) @(posedge clk);
      #1 en = 1'b0;
      @(negedge clk); #1;
      chk("ratio0_pulses", 32'(vcount - v0), 32'd0);

      // Asynchronous reset between edges, then clean restart in ramp mode.
      ratio = 8'hFF; mode = 2'd1; en = 1'b1;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_data",   data_o,       32'h0000_0000);
      chk("arst_data_n", data_n_o,     32'hFFFF_FFFF);
      chk("arst_valid",  32'(valid_o), 32'd0);
      chk("arst_cnt",    sample_cnt_o, 32'd0);
      push(32'h0302_0100, 32'hFFFF_FFFF, 32'd1);
      push(32'h0403_0201, 32'hFFFF_FFFF, 32'd2);
      sb_on = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_reload_valid", 32'(valid_o), 32'd0);
      repeat (2) @(posedge clk);
      #1 en = 1'b0;
      drain_check("arst_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_pattern_gen.md
# adc_pattern_gen

Synthesizable, parametrised multi-channel ADC stimulus generator producing per-channel sample words, their bitwise complement (differential-pair emulation), and a statistically throttled data-valid strobe. It replaces hand-written per-channel random stimulus in FMC ADC benches and also serves as an in-FPGA test source ahead of the acquisition core when no physical ADC is present. All channels share one clock domain and one valid strobe.

## Interface

- g_num_channels, 4, number of ADC channels (1..8)
- g_data_width, 16, bits per channel sample (1..32)
- g_lfsr_seed, 32'h1234_5678, base seed for the per-channel data LFSRs

- clk_sys_i  in  1  system clock; all logic rising-edge
- sys_rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
- en_i  in  1  generator enable; low freezes all state, forces valid_o=0
- clr_i  in  1  synchronous clear of generator state and sample counter
- mode_i  in  2  0 constant, 1 ramp, 2 pseudo-random, 3 alternating
- const_i  in  g_data_width  value driven on every channel in mode 0
- valid_ratio_i  in  8  valid density; 8'hFF = every enabled cycle, 0 = never
- data_o  out  g_num_channels*g_data_width  channel k at bits [k*W +: W]
- data_n_o  out  g_num_channels*g_data_width  bitwise ~data_o, same cycle
- valid_o  out  1  sample strobe
- sample_cnt_o  out  32  number of valid_o pulses since reset/clear, wraps

## Operation

- Reset (async assert, sync deassert by system): data_o=0, data_n_o=all ones, valid_o=0, sample_cnt_o=0, ramp[k]=k mod 2^W, lfsr[k]=seed_k, valid LFSR=16'hACE1, alt phase=0, mode_q=0.
- seed_k = g_lfsr_seed + k; if result is 0, seed_k = 1.
- Valid decision (each enabled cycle): 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1 steps every enabled cycle; dec = (valid_ratio_i==8'hFF) or (vlfsr[7:0] < valid_ratio_i).
- Cycle with en_i=1 and dec=1: data_o <= current pattern value, valid_o <= 1, sample_cnt_o += 1 (wraps 2^32-1 -> 0), pattern state advances.
- Cycle with en_i=1 and dec=0: data_o holds, valid_o <= 0, pattern state holds.
- en_i=0: valid_o <= 0, everything else holds (including valid LFSR).
- Patterns, per channel k:
  - mode 0: value = const_i; no state.
  - mode 1: value = ramp[k]; advance ramp[k] += 1 mod 2^W (2^W-1 -> 0).
  - mode 2: value = lfsr[k][W-1:0]; advance 32-bit Galois LFSR, mask 32'h8020_0003 (shift right, xor mask when lsb=1).
  - mode 3: value = W-bit 0101..01 pattern (LSB=1) if (phase xor k[0])=0, else 1010..10; advance toggles shared phase.
- Mode change: mode_i registered into mode_q; when mode_i != mode_q, that cycle reloads ramp, lfsr, phase to reset values, valid_o <= 0, no data update; pattern generation resumes next cycle. sample_cnt_o unaffected.
- clr_i=1: same reload as mode change plus sample_cnt_o <= 0, valid_o <= 0; data_o holds. clr_i has priority over en_i.
- data_n_o is always registered as ~next data_o, never lagging.

## Timing

- Latency: en_i/dec sampled at edge n -> data_o/valid_o updated at edge n (visible cycle n+1); one register stage.
- With valid_ratio_i=8'hFF and en_i steady high, valid_o is continuous from the second enabled cycle after any mode change/clear.
- valid_ratio_i, const_i sampled every cycle; changes take effect on the next decision.
- Simultaneous clr_i and mode change: single reload, counter cleared.
- Reset mid-operation: outputs go to reset values immediately (async), no glitching of valid_o afterward until en_i decision.
- Valid density over 2^16-1 cycles equals (number of 8-bit vlfsr values < ratio) / period; bench tolerance ±2%.

## Test plan

- Reset then en=1, mode=1, ratio=FF, N=4, W=16: ch0 emits 0,1,2,...; ch3 emits 3,4,...; data_n_o = ~data_o every cycle; sample_cnt_o=10 after 10 pulses.
- Ramp wrap, W=4: ch0 sequence 14,15,0,1 on consecutive valid pulses.
- mode=3, ratio=FF, W=8: ch0 55,AA,55..., ch1 AA,55,AA...; switch to mode 0 with const 8'h3C: one valid_o=0 cycle, then all channels 3C.
- mode=2, ratio=8'h80, 65535 enabled cycles: valid count within 50%±2%; ch0 first sample equals seed 0x1234_5678 low W bits; regenerate identical sequence after clr_i.
- ratio=0: valid_o never asserts over 1000 cycles; en_i=0 with ratio=FF: valid_o=0, data frozen.
- Assert sys_rst_n_i low mid-stream asynchronously (between edges): data_o=0, data_n_o=all ones, valid_o=0, counter 0 before next edge.
